// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_pkg
// Purpose  : Shared types and constants for the fetch sequencer slice.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_seq_pkg;

  localparam int unsigned MEM_TIMEOUT_DEF = 15;
  localparam int unsigned CYCLE_W_DEF     = 16;
  localparam int unsigned WAIT_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_FETCH   = 3'd2,
    ST_EXEC    = 3'd3,
    ST_MEM     = 3'd4,
    ST_ADVANCE = 3'd5,
    ST_HALT    = 3'd6,
    ST_ERROR   = 3'd7
  } seq_state_t;

  // States in which a program is actively executing.
  function automatic logic is_busy_state(input seq_state_t s);
    return (s == ST_INIT) || (s == ST_FETCH) || (s == ST_EXEC) ||
           (s == ST_MEM)  || (s == ST_ADVANCE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_if
// Purpose  : PC / IR / register-file / data-memory control bundle between
//            the sequencer (master) and the datapath (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if;

  logic pcStart;
  logic nextIns;
  logic jumpFlag;
  logic irLoad;
  logic regWrite;
  logic memReq;
  logic pcDone;
  logic isMemOp;
  logic isBranch;
  logic branchTaken;
  logic memAck;

  modport master (
    output pcStart, nextIns, jumpFlag, irLoad, regWrite, memReq,
    input  pcDone, isMemOp, isBranch, branchTaken, memAck
  );

  modport slave (
    input  pcStart, nextIns, jumpFlag, irLoad, regWrite, memReq,
    output pcDone, isMemOp, isBranch, branchTaken, memAck
  );

endinterface
`default_nettype wire

// File: rtl/fetch_sequencer_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : seq_wait_timer
// Purpose  : Clear/enable wait counter; expire_o flags the enabled cycle in
//            which the count reaches LIMIT.
// Revision : 1.0 - initial release
// ============================================================================
module seq_wait_timer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned LIMIT = MEM_TIMEOUT_DEF
) (
  input  wire logic clock,
  input  wire logic reset_n,
  input  wire logic clear_i,
  input  wire logic enable_i,
  output logic      expire_o
);

  logic [WAIT_W-1:0] count_q;

  // Count enabled cycles since the last clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + WAIT_W'(1);
    end
  end

  // The increment in this cycle lands on LIMIT.
  always_comb begin
    expire_o = enable_i && (count_q == WAIT_W'(LIMIT - 1));
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Top-level control FSM of the single-cycle-issue core, with a
//            saturating busy-cycle counter and memory handshake timeout.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CYCLE_W     = CYCLE_W_DEF
) (
  input  wire logic               clock,
  input  wire logic               reset_n,
  input  wire logic               go,
  fetch_sequencer_if.master       bus,
  output logic                    busy,
  output logic                    finished,
  output logic                    timeout,
  output logic [CYCLE_W-1:0]      cycleCount
);

  seq_state_t         state_q, state_d;
  logic               br_q;
  logic               jmp_q;
  logic [CYCLE_W-1:0] cycle_count_q;
  logic               w_mem_expire;

  seq_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_i  (state_q == ST_EXEC),
    .enable_i (state_q == ST_MEM),
    .expire_o (w_mem_expire)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; completion check takes priority over execution in EXEC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (go) state_d = ST_INIT;
      ST_INIT:    state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_EXEC;
      ST_EXEC: begin
        if (bus.pcDone)       state_d = ST_HALT;
        else if (bus.isMemOp) state_d = ST_MEM;
        else                  state_d = ST_ADVANCE;
      end
      ST_MEM: begin
        if (bus.memAck)        state_d = ST_ADVANCE;
        else if (w_mem_expire) state_d = ST_ERROR;
      end
      ST_ADVANCE: state_d = ST_FETCH;
      ST_HALT:    if (go) state_d = ST_INIT;
      ST_ERROR:   if (go) state_d = ST_INIT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Capture branch decode of the instruction being executed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      br_q  <= 1'b0;
      jmp_q <= 1'b0;
    end else if ((state_q == ST_EXEC) && !bus.pcDone) begin
      br_q  <= bus.isBranch;
      jmp_q <= bus.isBranch && bus.branchTaken;
    end
  end

  // Busy-cycle counter: restarts at INIT, saturates at all-ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count_q <= '0;
    end else if (state_q == ST_INIT) begin
      cycle_count_q <= '0;
    end else if (is_busy_state(state_q) && (cycle_count_q != '1)) begin
      cycle_count_q <= cycle_count_q + CYCLE_W'(1);
    end
  end

  // Moore output decode.
  always_comb begin
    bus.pcStart  = (state_q == ST_INIT);
    bus.irLoad   = (state_q == ST_FETCH);
    bus.memReq   = (state_q == ST_MEM);
    bus.nextIns  = (state_q == ST_ADVANCE);
    bus.jumpFlag = (state_q == ST_ADVANCE) && jmp_q;
    bus.regWrite = (state_q == ST_ADVANCE) && !br_q;
    busy         = is_busy_state(state_q);
    finished     = (state_q == ST_HALT);
    timeout      = (state_q == ST_ERROR);
    cycleCount   = cycle_count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Directed bench with a cycle-level behavioural model of the
//            sequencer plus literal checks of key timing points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam int unsigned TO  = 15;
  localparam int unsigned CW  = 6;
  localparam int          MAX = (1 << CW) - 1;

  // Model phases named after the program-level activity.
  localparam int PH_IDLE = 0, PH_INIT = 1, PH_FETCH = 2, PH_EXEC = 3,
                 PH_MEM  = 4, PH_ADV  = 5, PH_HALT  = 6, PH_ERR  = 7;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b1;
  logic          go      = 1'b0;
  logic          busy, finished, timeout;
  logic [CW-1:0] cycleCount;

  fetch_sequencer_if bus_if ();

  fetch_sequencer #(
    .MEM_TIMEOUT (TO),
    .CYCLE_W     (CW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .go         (go),
    .bus        (bus_if),
    .busy       (busy),
    .finished   (finished),
    .timeout    (timeout),
    .cycleCount (cycleCount)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ph   = PH_IDLE;
  int m_wait = 0;
  int m_cnt  = 0;
  bit m_br   = 0;
  bit m_jmp  = 0;

  function automatic bit running(input int ph);
    return ph == PH_INIT || ph == PH_FETCH || ph == PH_EXEC ||
           ph == PH_MEM  || ph == PH_ADV;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_ph = PH_IDLE; m_wait = 0; m_cnt = 0; m_br = 0; m_jmp = 0;
    end else begin
      if (m_ph == PH_INIT)                    m_cnt = 0;
      else if (running(m_ph) && m_cnt < MAX)  m_cnt = m_cnt + 1;
      case (m_ph)
        PH_IDLE, PH_HALT, PH_ERR: if (go) m_ph = PH_INIT;
        PH_INIT:  m_ph = PH_FETCH;
        PH_FETCH: m_ph = PH_EXEC;
        PH_EXEC: begin
          if (bus_if.pcDone) m_ph = PH_HALT;
          else begin
            m_br  = bus_if.isBranch;
            m_jmp = bus_if.isBranch && bus_if.branchTaken;
            if (bus_if.isMemOp) begin m_wait = 0; m_ph = PH_MEM; end
            else m_ph = PH_ADV;
          end
        end
        PH_MEM: begin
          m_wait = m_wait + 1;
          if (bus_if.memAck)      m_ph = PH_ADV;
          else if (m_wait >= TO)  m_ph = PH_ERR;
        end
        PH_ADV:  m_ph = PH_FETCH;
        default: m_ph = PH_IDLE;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    chk("pcStart",    int'(bus_if.pcStart),  int'(m_ph == PH_INIT));
    chk("irLoad",     int'(bus_if.irLoad),   int'(m_ph == PH_FETCH));
    chk("memReq",     int'(bus_if.memReq),   int'(m_ph == PH_MEM));
    chk("nextIns",    int'(bus_if.nextIns),  int'(m_ph == PH_ADV));
    chk("jumpFlag",   int'(bus_if.jumpFlag), int'(m_ph == PH_ADV && m_jmp));
    chk("regWrite",   int'(bus_if.regWrite), int'(m_ph == PH_ADV && !m_br));
    chk("busy",       int'(busy),            int'(running(m_ph)));
    chk("finished",   int'(finished),        int'(m_ph == PH_HALT));
    chk("timeout",    int'(timeout),         int'(m_ph == PH_ERR));
    chk("cycleCount", int'(cycleCount),      m_cnt);
  end

  // ---------------- stimulus ----------------
  int memreq_cycles;
  bit adv_next, adv_jmp, adv_rw, adv_to;

  // Entered at the FETCH negedge; returns at the next FETCH negedge, or at
  // the ERROR negedge when ack_at is 0 (no acknowledge).
  task automatic do_instr(input bit mem, input bit br, input bit tk, input int ack_at);
    bus_if.isMemOp     = mem;
    bus_if.isBranch    = br;
    bus_if.branchTaken = tk;
    bus_if.pcDone      = 1'b0;
    memreq_cycles      = 0;
    @(negedge clock);                        // EXEC
    if (mem) begin
      for (int i = 1; i <= int'(TO); i++) begin
        @(negedge clock);                    // MEM cycle i
        if (bus_if.memReq) memreq_cycles++;
        if (i == ack_at) begin
          bus_if.memAck = 1'b1;
          break;
        end
      end
    end
    @(negedge clock);                        // ADVANCE or ERROR
    bus_if.memAck = 1'b0;
    adv_next = bus_if.nextIns;
    adv_jmp  = bus_if.jumpFlag;
    adv_rw   = bus_if.regWrite;
    adv_to   = timeout;
    bus_if.isMemOp = 1'b0; bus_if.isBranch = 1'b0; bus_if.branchTaken = 1'b0;
    if (!adv_to) @(negedge clock);           // FETCH
  endtask

  initial begin
    bus_if.pcDone = 1'b0; bus_if.isMemOp = 1'b0; bus_if.isBranch = 1'b0;
    bus_if.branchTaken = 1'b0; bus_if.memAck = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_busy", int'(busy), 0);
    chk("idle_count", int'(cycleCount), 0);

    // First run: plain ALU instruction, go held high while busy.
    go = 1'b1;
    @(negedge clock);                        // INIT
    chk("init_pcStart", int'(bus_if.pcStart), 1);
    chk("init_busy", int'(busy), 1);
    @(negedge clock);                        // FETCH
    chk("fetch_irLoad", int'(bus_if.irLoad), 1);
    do_instr(0, 0, 0, 0);
    go = 1'b0;
    chk("alu_next", int'(adv_next), 1);
    chk("alu_rw", int'(adv_rw), 1);
    chk("alu_jmp", int'(adv_jmp), 0);
    chk("alu_count", int'(cycleCount), 3);

    do_instr(0, 1, 1, 0);
    chk("brT_next", int'(adv_next), 1);
    chk("brT_jmp", int'(adv_jmp), 1);
    chk("brT_rw", int'(adv_rw), 0);
    do_instr(0, 1, 0, 0);
    chk("brN_jmp", int'(adv_jmp), 0);
    chk("brN_rw", int'(adv_rw), 0);

    do_instr(1, 0, 0, 4);
    chk("ld4_memreq", memreq_cycles, 4);
    chk("ld4_next", int'(adv_next), 1);
    chk("ld4_rw", int'(adv_rw), 1);
    do_instr(1, 0, 0, 15);
    chk("ld15_memreq", memreq_cycles, 15);
    chk("ld15_to", int'(adv_to), 0);
    chk("ld15_next", int'(adv_next), 1);

    // Completion: count = 3+3+3+7+18 + FETCH + EXEC = 36.
    bus_if.pcDone = 1'b1;
    @(negedge clock);                        // EXEC
    @(negedge clock);                        // HALT
    chk("halt_fin", int'(finished), 1);
    chk("halt_busy", int'(busy), 0);
    chk("halt_next", int'(bus_if.nextIns), 0);
    chk("halt_count", int'(cycleCount), 36);
    bus_if.pcDone = 1'b0;
    repeat (3) @(negedge clock);
    chk("halt_hold", int'(cycleCount), 36);
    go = 1'b1;
    @(negedge clock);                        // INIT
    go = 1'b0;
    chk("rst_pcStart", int'(bus_if.pcStart), 1);
    chk("rst_fin", int'(finished), 0);
    @(negedge clock);                        // FETCH
    chk("rst_pcStart2", int'(bus_if.pcStart), 0);
    chk("rst_count", int'(cycleCount), 0);

    // Timeout: FETCH + EXEC + 15 MEM = 17 busy cycles.
    do_instr(1, 0, 0, 0);
    chk("to_flag", int'(adv_to), 1);
    chk("to_memreq", memreq_cycles, 15);
    chk("to_busy", int'(busy), 0);
    chk("to_count", int'(cycleCount), 17);

    // Asynchronous reset in the middle of a memory wait.
    go = 1'b1;
    @(negedge clock);                        // INIT
    go = 1'b0;
    @(negedge clock);                        // FETCH
    bus_if.isMemOp = 1'b1;
    @(negedge clock);                        // EXEC
    @(negedge clock);                        // MEM
    chk("mid_memreq", int'(bus_if.memReq), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_memreq", int'(bus_if.memReq), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_count", int'(cycleCount), 0);
    bus_if.isMemOp = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("ar_idle_start", int'(bus_if.pcStart), 0);

    // Saturation: 22 ALU instructions would reach 66; counter stops at 63.
    go = 1'b1;
    @(negedge clock);                        // INIT
    go = 1'b0;
    @(negedge clock);                        // FETCH
    for (int k = 0; k < 22; k++) do_instr(0, 0, 0, 0);
    chk("sat_count", int'(cycleCount), MAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: run did not complete, limit reached at t=%0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Top-level control FSM for the single-cycle-issue core.
- Drives the program counter's start/nextIns/jumpFlag controls, the instruction-register load, register-file write enable and the data-memory request handshake.
- Detects program completion via the PC's done flag and reports status to the testbench/host.
- Counts executed cycles for performance reporting.

Parameters:
MEM_TIMEOUT, 15, maximum cycles to wait for memAck before entering ERROR (1..255)
CYCLE_W, 16, width of cycleCount

Ports:
clock  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
go  input  1  host request to run program; level, sampled in IDLE/HALT/ERROR
pcDone  input  1  done flag from program counter
isMemOp  input  1  decoded current instruction is a load/store
isBranch  input  1  decoded current instruction is a branch
branchTaken  input  1  ALU branch condition result
memAck  input  1  data memory completion strobe
pcStart  output  1  load PC with starting address
nextIns  output  1  advance PC one step
jumpFlag  output  1  apply branch offset on this advance
irLoad  output  1  latch instruction memory output
regWrite  output  1  register-file write enable
memReq  output  1  data memory request, held until memAck
busy  output  1  program executing
finished  output  1  program reached done address
timeout  output  1  memory handshake timed out
cycleCount  output  CYCLE_W  cycles spent busy

Behaviour:
- States: IDLE, INIT, FETCH, EXEC, MEM, ADVANCE, HALT, ERROR. All outputs are Moore, decoded from the state register plus latched flags.
- Reset (async, reset_n=0): state=IDLE; every output 0; cycleCount=0; latched flags and wait counter cleared. Reset takes effect immediately, including mid-MEM; memReq drops without waiting for memAck.
- IDLE: go=1 -> INIT, else stay.
- INIT: pcStart=1, busy=1; cycleCount cleared to 0; -> FETCH. Exactly one pcStart cycle per run.
- FETCH: irLoad=1; -> EXEC.
- EXEC: evaluate in this priority:
  - pcDone=1 -> HALT. The instruction at the done address is not executed.
  - Otherwise latch isBranch and jmp = isBranch & branchTaken.
  - isMemOp=1 -> MEM, wait counter cleared.
  - Otherwise -> ADVANCE.
- MEM: memReq=1 held.
  - memAck=1 -> ADVANCE.
  - Otherwise the wait counter increments. On reaching MEM_TIMEOUT -> ERROR.
  - memAck in the same cycle the counter reaches MEM_TIMEOUT: ack wins -> ADVANCE.
- ADVANCE: nextIns=1 for exactly one cycle; jumpFlag=latched jmp; regWrite = NOT latched isBranch; -> FETCH.
- HALT: finished=1, busy=0, cycleCount held. go=1 -> INIT (restart clears finished on entry to INIT).
- ERROR: timeout=1, busy=0, cycleCount held. go=1 -> INIT.
- busy=1 in INIT, FETCH, EXEC, MEM, ADVANCE only.
- cycleCount: increments by 1 every cycle busy=1. Saturates at all-ones, no wrap. Cleared only in INIT or reset.
- go while busy is ignored.
- memAck outside MEM is ignored. isMemOp, isBranch and branchTaken are sampled only in EXEC.
- nextIns, pcStart and jumpFlag are never asserted together. jumpFlag only ever accompanies nextIns.
- Minimum instruction latency: 3 cycles (FETCH, EXEC, ADVANCE). Memory instruction: 4 + (memAck wait) cycles.

Decomposition:
- Package fetch_seq_pkg: state enum (seq_state_t, 3-bit), default MEM_TIMEOUT and CYCLE_W constants, wait-counter width (8).
- One sub-module: seq_wait_timer (clear/enable/expire counter with MEM_TIMEOUT threshold), instantiated for the MEM handshake.
- FSM and cycle counter stay in fetch_sequencer.

Test Plan:
- Reset low mid-MEM with memReq=1 -> all outputs 0 in the same cycle; state IDLE after release; cycleCount=0.
- go=1, ALU instr (isMemOp=0, isBranch=0) -> pcStart at cycle 1, irLoad at 2, nextIns+regWrite at 4 with jumpFlag=0; cycleCount=3 after first ADVANCE.
- Branch with branchTaken=1 -> ADVANCE shows nextIns=1, jumpFlag=1, regWrite=0. With branchTaken=0 -> jumpFlag=0.
- Load, memAck after 4 MEM cycles -> memReq high exactly 4 cycles, then nextIns. No ack for 15 cycles -> timeout=1, busy=0. Ack exactly on cycle 15 -> ADVANCE, no timeout.
- pcDone=1 in EXEC -> HALT: finished=1, busy=0, no nextIns. cycleCount frozen; go=1 restarts with a single pcStart and finished cleared.
- Force cycleCount to 16'hFFFE and run 5 more cycles -> saturates at 16'hFFFF.
